// File: rtl/spc2_tx.sv
// spc2_tx: serial configuration transmitter for the 14-bit spc2 shift register.
// Each frame is a reset pulse on Cfg_resetn, then 14 LSB-first bits on Cfg_out,
// one Sclk rise per bit, and a final Sclk low phase that fires spc2's load strobe.
//
// Optional build macro: SPC2_TX_SHADOW_EN
//   defined   - field inputs are captured into a shadow word on Start accept
//   undefined - fields are read live at each bit's SHLO entry (hold them while Busy)
//
// state | meaning
// IDLE  | waiting for Start, Sclk low, spc2 released from reset
// RSTP  | Cfg_resetn low for 2*HALF cycles, clears spc2 fields and bit counter
// SHLO  | Sclk low half-period, Cfg_out presents word[idx]
// SHHI  | Sclk high half-period, Cfg_out held (spc2 samples on the rise)
// TAIL  | Sclk low half-period after the last bit, spc2 load strobe fires

module spc2_tx #(
  parameter int unsigned HALF = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] F,
  input  logic       IQ,
  input  logic [3:0] GS,
  input  logic       CE,
  input  logic       NS,
  input  logic [2:0] GD,
  output logic       Sclk,
  output logic       Cfg_out,
  output logic       Cfg_resetn,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RSTP = 3'd1,
    SHLO = 3'd2,
    SHHI = 3'd3,
    TAIL = 3'd4
  } state_t;

  localparam logic [8:0] HALF_M1 = 9'(HALF - 1);
  localparam logic [8:0] FULL_M1 = 9'(2 * HALF - 1);
  localparam logic [3:0] LAST_BIT = 4'd13;

  state_t     state_q, state_d;
  logic [8:0] phase_q, phase_d;
  logic [3:0] idx_q, idx_d;
  logic       sclk_q, sclk_d;
  logic       cfg_q, cfg_d;
  logic       resetn_q, resetn_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       phase_end;
  logic [13:0] word;

`ifdef SPC2_TX_SHADOW_EN
  logic [13:0] shadow_q, shadow_d;

  // Shadow word is loaded only on the Start-accept edge.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == IDLE && Start) begin
      shadow_d = {F, IQ, GS, CE, NS, GD};
    end
  end

  // Shadow word register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign word = shadow_q;
`else
  assign word = {F, IQ, GS, CE, NS, GD};
`endif

  // RSTP lasts a full Sclk period, every other phase a half period.
  assign phase_end = (state_q == RSTP) ? (phase_q == FULL_M1) : (phase_q == HALF_M1);

  // Next-state, phase counter and bit index.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 9'd1;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        idx_d   = '0;
        if (Start) begin
          state_d = RSTP;
        end
      end
      RSTP: begin
        if (phase_end) begin
          state_d = SHLO;
          phase_d = '0;
        end
      end
      SHLO: begin
        if (phase_end) begin
          state_d = SHHI;
          phase_d = '0;
        end
      end
      SHHI: begin
        if (phase_end) begin
          phase_d = '0;
          if (idx_q < LAST_BIT) begin
            idx_d   = idx_q + 4'd1;
            state_d = SHLO;
          end else begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (phase_end) begin
          state_d = IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    sclk_d   = (state_d == SHHI);
    resetn_d = (state_d != RSTP);
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == TAIL) && phase_end;
    cfg_d    = cfg_q;
    if (state_d == SHLO && state_q != SHLO) begin
      cfg_d = word[idx_d];
    end else if (state_d == IDLE || state_d == RSTP) begin
      cfg_d = 1'b0;
    end
  end

  // State and output registers; Reset also holds spc2 in reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      idx_q    <= '0;
      sclk_q   <= 1'b0;
      cfg_q    <= 1'b0;
      resetn_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      sclk_q   <= sclk_d;
      cfg_q    <= cfg_d;
      resetn_q <= resetn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Sclk       = sclk_q;
  assign Cfg_out    = cfg_q;
  assign Cfg_resetn = resetn_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_spc2_tx.sv
// Bench for spc2_tx: two instances (HALF=1 and HALF=3) driven frame by frame
// and compared cycle by cycle with a timeline model of the frame, plus an
// spc2 shift-register model that captures Cfg_out on each Sclk rise.

module tb_spc2_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [3:0] f, gs;
  logic       iq, ce, ns;
  logic [2:0] gd;
  logic       sclk1, cfg1, rstn1, busy1, done1;
  logic       sclk3, cfg3, rstn3, busy3, done3;

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;

  always #5 clk = ~clk;

  spc2_tx #(.HALF(1)) u_dut1 (
    .Clk(clk), .Reset(reset), .Start(start1),
    .F(f), .IQ(iq), .GS(gs), .CE(ce), .NS(ns), .GD(gd),
    .Sclk(sclk1), .Cfg_out(cfg1), .Cfg_resetn(rstn1), .Busy(busy1), .Done(done1)
  );

  spc2_tx #(.HALF(3)) u_dut3 (
    .Clk(clk), .Reset(reset), .Start(start3),
    .F(f), .IQ(iq), .GS(gs), .CE(ce), .NS(ns), .GD(gd),
    .Sclk(sclk3), .Cfg_out(cfg3), .Cfg_resetn(rstn3), .Busy(busy3), .Done(done3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {Done, Busy, Cfg_resetn, Cfg_out, Sclk} of the selected instance
  function automatic logic [4:0] obs_vec();
    if (sel != 0) return {done3, busy3, rstn3, cfg3, sclk3};
    return {done1, busy1, rstn1, cfg1, sclk1};
  endfunction

  function automatic int half_of_sel();
    return (sel != 0) ? 3 : 1;
  endfunction

  task automatic set_word(input logic [13:0] w);
    {f, iq, gs, ce, ns, gd} = w;
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start3 = v;
    else start1 = v;
  endtask

  // Expected pins c cycles after the accept edge, from the frame timeline.
  task automatic model(input int c, input int h, input logic [13:0] w,
                       output logic [4:0] e, output logic [4:0] m);
    int s, k, p;
    m = 5'b11111;
    if (c <= 2 * h) begin
      e = 5'b01000;
    end else if (c <= 30 * h) begin
      s = c - 2 * h - 1;
      k = s / (2 * h);
      p = s % (2 * h);
      e = {1'b0, 1'b1, 1'b1, w[k], (p >= h)};
    end else if (c <= 31 * h) begin
      e = 5'b01100;
      m = 5'b11101;
    end else begin
      e = 5'b10100;
    end
  endtask

  // Starts at the first negedge after the accept edge.
  task automatic run_frame(input logic [13:0] w_exp, input logic [13:0] w_change, input bit do_change,
                           input bit keep, input bit mid_start, input int abort_c);
    int h, total, rises, last_rise, busy_cnt, rstn_low;
    logic [13:0] sr;
    logic prev_sclk;
    logic [4:0] v, e, m;
    h = half_of_sel();
    total = 31 * h;
    sr = '0; rises = 0; last_rise = -1; busy_cnt = 0; rstn_low = 0; prev_sclk = 1'b0;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        set_start(keep);
        if (do_change) set_word(w_change);
      end
      if (mid_start && c == 10 * h) set_start(1'b1);
      if (mid_start && c == 10 * h + 1) set_start(1'b0);
      v = obs_vec();
      model(c, h, w_exp, e, m);
      check_eq($sformatf("wave h%0d c%0d", h, c), 32'(v & m), 32'(e & m));
      if (v[0] && !prev_sclk) begin
        sr = {v[1], sr[13:1]};
        rises++;
        if (last_rise >= 0) check_eq("sclk period", 32'(c - last_rise), 32'(2 * h));
        last_rise = c;
      end
      prev_sclk = v[0];
      if (v[3]) busy_cnt++;
      if (!v[2]) rstn_low++;
      if (c == abort_c) begin
        reset = 1'b1;
        set_start(1'b0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check_eq($sformatf("abort outs %0d", j), 32'(obs_vec()), 32'h0);
        end
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check_eq($sformatf("post abort idle %0d", j), 32'(obs_vec()), 32'b00100);
        end
        return;
      end
    end
    check_eq("spc2 word", 32'(sr), 32'(w_exp));
    check_eq("sclk rises", 32'(rises), 32'd14);
    check_eq("busy cycles", 32'(busy_cnt), 32'(31 * h));
    check_eq("resetn low cycles", 32'(rstn_low), 32'(2 * h));
  endtask

  task automatic accept();
    @(negedge clk);
    set_start(1'b1);
  endtask

  task automatic check_idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check_eq($sformatf("idle %0d", j), 32'(obs_vec()), 32'b00100);
    end
  endtask

  initial begin
    logic [13:0] w, w2, wexp;
    int nb;
    bit mid;
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    set_word(14'h0);
    repeat (3) @(negedge clk);
    sel = 0; check_eq("reset outs h1", 32'(obs_vec()), 32'h0);
    sel = 1; check_eq("reset outs h3", 32'(obs_vec()), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    sel = 0; check_eq("after reset h1", 32'(obs_vec()), 32'b00100);
    sel = 1; check_eq("after reset h3", 32'(obs_vec()), 32'b00100);

    // Basic frame, HALF=1
    sel = 0;
    set_word(14'h2AAE);
    accept();
    run_frame(14'h2AAE, 14'h0, 1'b0, 1'b0, 1'b0, -1);
    check_idle(3);

    // Divided clock, HALF=3, all ones
    sel = 1;
    set_word(14'h3FFF);
    accept();
    run_frame(14'h3FFF, 14'h0, 1'b0, 1'b0, 1'b0, -1);
    check_idle(3);

    // Reset after the 7th Sclk rise, then a clean frame on both widths
    for (int s = 0; s < 2; s++) begin
      sel = s;
      set_word(14'h1C35);
      accept();
      run_frame(14'h1C35, 14'h0, 1'b0, 1'b0, 1'b0, 15 * half_of_sel() + 2);
      set_word(14'h0A5B);
      accept();
      run_frame(14'h0A5B, 14'h0, 1'b0, 1'b0, 1'b0, -1);
      check_idle(2);
    end

    // Start pulsed while busy is ignored
    sel = 0;
    set_word(14'h1234);
    accept();
    run_frame(14'h1234, 14'h0, 1'b0, 1'b0, 1'b1, -1);
    check_idle(4);

    // Start held high: back-to-back frames
    sel = 1;
    set_word(14'h2B1D);
    accept();
    run_frame(14'h2B1D, 14'h0, 1'b0, 1'b1, 1'b0, -1);
    run_frame(14'h2B1D, 14'h0, 1'b0, 1'b1, 1'b0, -1);
    run_frame(14'h2B1D, 14'h0, 1'b0, 1'b0, 1'b0, -1);
    check_idle(2);

    // F changed to 3 after accept
    for (int s = 0; s < 2; s++) begin
      sel = s;
      w = 14'h2AAE;
      w2 = {4'h3, w[9:0]};
`ifdef SPC2_TX_SHADOW_EN
      wexp = w;
`else
      wexp = w2;
`endif
      set_word(w);
      accept();
      run_frame(wexp, w2, 1'b1, 1'b0, 1'b0, -1);
      check_idle(2);
    end

    // Randomized frames
    for (int i = 0; i < 12; i++) begin
      sel = int'($urandom_range(0, 1));
      w = 14'($urandom);
      nb = int'($urandom_range(1, 2));
      mid = (nb == 1) && ($urandom_range(0, 1) == 1);
      set_word(w);
      accept();
      for (int b = 0; b < nb; b++) begin
        run_frame(w, 14'h0, 1'b0, (b < nb - 1), mid, -1);
      end
      check_idle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spc2_tx.md
# spc2_tx

Serial configuration transmitter driving the 14-bit serial-to-parallel configuration register (spc2) directly upstream. Accepts one parallel configuration word (F, IQ, GS, CE, NS, GD) on a Start request and produces the complete spc2 frame:
- a reset pulse on spc2's Resetn;
- 14 data bits on Cfg_in, each with one rising edge of the generated serial clock;
- a final serial-clock low phase that fires spc2's internal load strobe.

All outputs are registered and glitch-free.

## Interface
- HALF, default 2: Clk cycles per Sclk half-period; legal range 1..255.
- Clk  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  frame request; sampled only in IDLE.
- F  in  4  frequency field.
- IQ  in  1  I/Q select.
- GS  in  4  gain-stage field.
- CE  in  1  chip enable field.
- NS  in  1  NS field.
- GD  in  3  GD field.
- Sclk  out  1  serial clock to spc2 Clk.
- Cfg_out  out  1  serial data to spc2 Cfg_in.
- Cfg_resetn  out  1  active-low reset to spc2 Resetn.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle pulse at frame completion.

## Operation
- **Word mapping:** word[13:0] = {F, IQ, GS, CE, NS, GD}.
  - Bit order is LSB first: word[0] (GD[0]) is sent first and word[13] (F[3]) last.
  - This order lands each field at its spc2 position after 14 shifts.
- **States:** IDLE, RSTP, SHLO, SHHI, TAIL.
- **IDLE:** Sclk=0, Cfg_out=0, Cfg_resetn=1, Busy=0.
  - Start=1 → RSTP on that edge.
  - Bit index is cleared to 0.
- **RSTP:** Cfg_resetn=0 and Sclk=0 for 2*HALF cycles.
  - This clears spc2's fields and its 4-bit counter; a pulse is required before every frame because that counter only strobes once per reset.
  - Then → SHLO.
- **SHLO:** Cfg_out=word[index], Sclk=0, for HALF cycles, then → SHHI.
- **SHHI:** Sclk=1 and Cfg_out held, for HALF cycles.
  - If index<13: increment index, → SHLO.
  - Otherwise → TAIL.
- **TAIL:** Sclk=0 for HALF cycles; Sclk's falling edge produces the spc2 load strobe. Then → IDLE.
  - Done=1 for exactly one cycle, in the first IDLE cycle.
- **Counters:**
  - Phase counter: 9 bits, counts 0..2*HALF-1.
  - Bit index: 4 bits, counts 0..13 and never wraps.
- **Start handling:**
  - Start while Busy is ignored and not queued.
  - Start held high continuously causes back-to-back frames: the next frame is accepted in the same cycle Done is high.
- **Reset:** asserted in any state, including mid-frame, it forces IDLE on the next edge. Outputs are then Sclk=0, Cfg_out=0, Cfg_resetn=0, Busy=0, Done=0.
  - Cfg_resetn=0 while Reset is high, so spc2 is held in reset along with this block.
  - The first IDLE cycle after Reset falls drives Cfg_resetn=1.
  - An aborted frame never produces Done.
- **Field visibility:** spc2 outputs read 0 from the RSTP phase until the TAIL strobe. This is accepted system behaviour.

## Timing
- Start accepted at edge t0; Busy=1 from the cycle after t0.
- RSTP occupies 2*HALF cycles.
- Bit k data is valid from the start of its SHLO phase, HALF cycles before its Sclk rising edge.
  - Data is held through SHHI, giving HALF cycles of hold after the rising edge.
- Busy is high for exactly 31*HALF cycles: RSTP 2*HALF, shift 28*HALF, TAIL HALF.
- Done is high in the cycle Busy returns to 0.
- Sclk duty is exactly 50% during shifting; period is 2*HALF Clk cycles.

## Configuration
- Macro: SPC2_TX_SHADOW_EN.
- **Defined:** all field inputs are captured into a 14-bit shadow register on the Start-accept edge.
  - Inputs may change freely while Busy.
  - Transmitted bits come from the shadow register.
- **Undefined:** no shadow register; word[index] is read combinationally from the input ports at each SHLO entry.
  - Inputs must be held stable while Busy.
  - A change is transmitted from the next SHLO onward.

## Test plan
- **Basic frame:** HALF=1, F=4'hA, IQ=1, GS=4'h5, CE=0, NS=1, GD=3'b110 (word 14'h2AAE), Start pulse.
  - Cfg_out sampled at Sclk rises must read 0,1,1,1,0,1,0,1,0,1,0,1,0,1.
  - Done arrives 31 cycles after accept.
  - A spc2 model shows the same field values after TAIL.
- **Divided clock:** HALF=3, word 14'h3FFF.
  - Busy high for 93 cycles, exactly 14 Sclk rises, Sclk period 6.
  - RSTP shows Cfg_resetn low for 6 cycles.
- **Reset mid-frame:** Reset asserted after the 7th Sclk rise.
  - Next edge: Sclk=0, Cfg_out=0, Cfg_resetn=0, Busy=0, and Done never pulses.
  - A new Start after Reset falls completes a correct frame.
- **Start handling:** Start pulsed while Busy is ignored, so only one frame is sent. Start held high gives back-to-back frames, each preceded by an RSTP pulse.
- **Shadow register:** with SPC2_TX_SHADOW_EN defined, change F to 4'h3 after the accept edge; the frame still carries 4'hA. Without the macro, the change is sent in the remaining bits.
